ifetch_ctrl_rv32i: RTL and testbench

Instruction-fetch sequencer for the single-cycle RV32I core. It owns the PC and drives the byte address of the 32-word synchronous instruction ROM, which has one cycle of read latency and outputs NOP while in reset. It tracks which PC the ROM output belongs to and presents instructions downstream with a valid/ready handshake. It also handles branch/jump redirects, back-pressure stalls (by replaying the ROM address), EBREAK halt, error flags and a retired-fetch counter.

---
 rtl/ifetch_ctrl_rv32i.sv | 140 ++++++++++++++
 tb/tb_ifetch_ctrl_rv32i.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl_rv32i.sv
// ============================================================================
// ifetch_ctrl_rv32i : RV32I fetch sequencer for a 1-cycle-latency instruction
// ROM, with valid/ready output, redirects, EBREAK halt and error flags.
// Revision 1.0
// ============================================================================
`default_nettype none

module ifetch_ctrl_rv32i #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ROM_WORDS    = 32,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        err_misaligned,
    output logic        err_range,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_ROM_BYTES = 32'(4 * ROM_WORDS);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_resp_pc;
    logic [31:0] w_resp_pc_nxt;
    logic        r_resp_vld;
    logic        w_resp_vld_nxt;
    logic        r_err_mis;
    logic        w_err_mis_nxt;
    logic        r_err_rng;
    logic        w_err_rng_nxt;
    logic [31:0] r_fetch_count;
    logic [31:0] w_fetch_count_nxt;

    logic [31:0] w_tgt;
    logic        w_stall;
    logic        w_accept;

    assign w_tgt    = {redirect_pc[31:2], 2'b00};
    assign w_stall  = r_resp_vld && !out_ready;
    assign w_accept = r_resp_vld && out_ready;

    // Stall and halt replay the displayed word so the ROM keeps out_instr stable.
    always_comb begin
        rom_addr = r_fetch_pc;
        if (reset) begin
            rom_addr = RESET_PC;
        end else if (redirect_valid) begin
            rom_addr = w_tgt;
        end else if (w_stall || (r_state == ST_HALT)) begin
            rom_addr = r_resp_pc;
        end
    end

    assign out_valid      = r_resp_vld;
    assign out_instr      = r_resp_vld ? rom_instr : NOP_INSTR;
    assign out_pc         = r_resp_pc;
    assign halted         = (r_state == ST_HALT);
    assign err_misaligned = r_err_mis;
    assign err_range      = r_err_rng;
    assign fetch_count    = r_fetch_count;

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_resp_pc_nxt     = r_resp_pc;
        w_resp_vld_nxt    = r_resp_vld;
        w_err_mis_nxt     = r_err_mis;
        w_err_rng_nxt     = r_err_rng || (rom_addr >= c_ROM_BYTES);
        w_fetch_count_nxt = r_fetch_count;

        if (w_accept && !redirect_valid) begin
            w_fetch_count_nxt = r_fetch_count + 32'd1;
        end

        if (redirect_valid) begin
            // The displayed instruction is squashed; the target shows next cycle.
            w_resp_pc_nxt  = w_tgt;
            w_resp_vld_nxt = 1'b1;
            w_fetch_pc_nxt = w_tgt + 32'd4;
            w_state_nxt    = ST_RUN;
            if (redirect_pc[1:0] != 2'b00) begin
                w_err_mis_nxt = 1'b1;
            end
        end else if (w_stall) begin
            w_resp_vld_nxt = r_resp_vld;
        end else if (r_state == ST_RUN) begin
            if (w_accept && (out_instr == EBREAK_INSTR)) begin
                w_state_nxt    = ST_HALT;
                w_resp_vld_nxt = 1'b0;
            end else begin
                w_resp_pc_nxt  = r_fetch_pc;
                w_resp_vld_nxt = 1'b1;
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
        end else begin
            w_resp_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_resp_vld    <= 1'b0;
            r_err_mis     <= 1'b0;
            r_err_rng     <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_resp_vld    <= w_resp_vld_nxt;
            r_err_mis     <= w_err_mis_nxt;
            r_err_rng     <= w_err_rng_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_ctrl_rv32i.sv
// ============================================================================
// tb_ifetch_ctrl_rv32i : vector table + scoreboard bench with a 32-word ROM model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_ctrl_rv32i;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        err_misaligned;
    logic        err_range;
    logic [31:0] fetch_count;

    logic [31:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halt;
        logic        mis;
        logic        rng;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    ifetch_ctrl_rv32i dut (
        .clock          (clock),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_instr      (rom_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .fetch_count    (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM, NOP in reset, aliases on ADDR[6:2].
    always @(posedge clock or posedge reset) begin
        if (reset) rom_instr <= c_NOP;
        else       rom_instr <= mem[rom_addr[6:2]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input vec_t e);
        chk({tag, ".valid"}, 32'(out_valid), 32'(e.vld));
        chk({tag, ".pc"}, out_pc, e.pc);
        chk({tag, ".instr"}, out_instr, e.instr);
        chk({tag, ".halted"}, 32'(halted), 32'(e.halt));
        chk({tag, ".err_mis"}, 32'(err_misaligned), 32'(e.mis));
        chk({tag, ".err_rng"}, 32'(err_range), 32'(e.rng));
        chk({tag, ".count"}, fetch_count, e.cnt);
    endtask

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic [31:0] addr, input logic vld, input logic [31:0] pc,
                       input logic [31:0] instr, input logic halt, input logic mis,
                       input logic rng, input logic [31:0] cnt);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.addr = addr; v.vld = vld; v.pc = pc;
        v.instr = instr; v.halt = halt; v.mis = mis; v.rng = rng; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t e;
        vec_t rst_exp;

        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0010_0293;
        mem[1] = 32'h0000_0333;
        mem[2] = 32'h00B0_0393;
        mem[4] = 32'h0053_0333;
        mem[8] = 32'h0010_0073;

        //   rdy rv rpc     addr    vld pc      instr    halt mis rng cnt
        add(1, 0, 32'h0,  32'h00, 1, 32'h00, mem[0],  0, 0, 0, 0);
        add(1, 0, 32'h0,  32'h04, 1, 32'h04, mem[1],  0, 0, 0, 1);
        add(1, 0, 32'h0,  32'h08, 1, 32'h08, mem[2],  0, 0, 0, 2);
        add(0, 0, 32'h0,  32'h08, 1, 32'h08, mem[2],  0, 0, 0, 2);
        add(0, 0, 32'h0,  32'h08, 1, 32'h08, mem[2],  0, 0, 0, 2);
        add(0, 0, 32'h0,  32'h08, 1, 32'h08, mem[2],  0, 0, 0, 2);
        add(1, 0, 32'h0,  32'h0C, 1, 32'h0C, mem[3],  0, 0, 0, 3);
        add(1, 0, 32'h0,  32'h10, 1, 32'h10, mem[4],  0, 0, 0, 4);
        add(1, 0, 32'h0,  32'h14, 1, 32'h14, mem[5],  0, 0, 0, 5);
        add(1, 0, 32'h0,  32'h18, 1, 32'h18, mem[6],  0, 0, 0, 6);
        add(1, 0, 32'h0,  32'h1C, 1, 32'h1C, mem[7],  0, 0, 0, 7);
        add(1, 1, 32'h10, 32'h10, 1, 32'h10, mem[4],  0, 0, 0, 7);
        add(1, 1, 32'h12, 32'h10, 1, 32'h10, mem[4],  0, 1, 0, 7);
        add(1, 0, 32'h0,  32'h14, 1, 32'h14, mem[5],  0, 1, 0, 8);
        add(1, 0, 32'h0,  32'h18, 1, 32'h18, mem[6],  0, 1, 0, 9);
        add(1, 0, 32'h0,  32'h1C, 1, 32'h1C, mem[7],  0, 1, 0, 10);
        add(1, 0, 32'h0,  32'h20, 1, 32'h20, mem[8],  0, 1, 0, 11);
        add(1, 0, 32'h0,  32'h24, 0, 32'h20, c_NOP,   1, 1, 0, 12);
        add(1, 0, 32'h0,  32'h20, 0, 32'h20, c_NOP,   1, 1, 0, 12);
        add(1, 1, 32'h0,  32'h00, 1, 32'h00, mem[0],  0, 1, 0, 12);
        add(1, 1, 32'h78, 32'h78, 1, 32'h78, mem[30], 0, 1, 0, 12);
        add(1, 0, 32'h0,  32'h7C, 1, 32'h7C, mem[31], 0, 1, 0, 13);
        add(1, 0, 32'h0,  32'h80, 1, 32'h80, mem[0],  0, 1, 1, 14);
        add(0, 0, 32'h0,  32'h80, 1, 32'h80, mem[0],  0, 1, 1, 14);

        rst_exp = '{rdy: 1'b0, rv: 1'b0, rpc: 32'h0, addr: 32'h0, vld: 1'b0, pc: 32'h0,
                    instr: c_NOP, halt: 1'b0, mis: 1'b0, rng: 1'b0, cnt: 32'h0};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", rst_exp);
        chk("reset.rom_addr", rom_addr, 32'h0);

        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clock);
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            sb_q.push_back(vecs[i]);
            #1;
            chk($sformatf("v%0d.rom_addr", i), rom_addr, vecs[i].addr);
            @(posedge clock);
            #1;
            e = sb_q.pop_front();
            chk_out($sformatf("v%0d", i), e);
        end

        // Reset asserted mid-stall must take effect without a clock edge.
        @(negedge clock);
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_out("midrst", rst_exp);
        chk("midrst.rom_addr", rom_addr, 32'h0);

        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        e = rst_exp;
        e.vld = 1'b1; e.instr = mem[0];
        chk_out("postrst", e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
